// File: rtl/seq_det_param.sv
// Serial pattern detector with a run-time loadable pattern, length and overlap
// mode. The Mealy output z fires in the same cycle the completing bit arrives.
// z_q is z delayed by one clock. match_cnt is a saturating count of matches.
module seq_det_param #(
   parameter int             N       = 8,
   parameter int             LEN_W   = 4,
   parameter int             CNT_W   = 8,
   parameter logic [N-1:0]   DEF_PAT = N'(8'b0000_1010),
   parameter int             DEF_LEN = 4,
   parameter bit             DEF_OVL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x,
   input  logic             in_valid,
   input  logic             cfg_load,
   input  logic [N-1:0]     pattern,
   input  logic [LEN_W-1:0] pat_len,
   input  logic             overlap,
   input  logic             clr_cnt,
   output logic             z,
   output logic             z_q,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cfg_err
);

   localparam logic [LEN_W-1:0] N_L = LEN_W'(N);

   logic [N-1:0]     pat_r;
   logic [LEN_W-1:0] len_r;
   logic             ovl_r;
   logic [N-2:0]     hist;
   logic [LEN_W-1:0] fill;

   logic [N-1:0]     window;
   logic [N-1:0]     mask;
   logic             pat_eq;
   logic             filled;

   // Increment that holds at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // Fill count saturates at N; beyond that the history is simply full.
   function automatic logic [LEN_W-1:0] fill_inc(input logic [LEN_W-1:0] f);
      return (f >= N_L) ? N_L : f + 1'b1;
   endfunction

   assign cfg_err = (len_r == '0) || (len_r > N_L);

   // Compare the newest len_r bits (history plus the bit on x) against the pattern.
   always_comb begin
      window = {hist, x};
      mask   = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (LEN_W'(i) < len_r);
      end
      pat_eq = ((window ^ pat_r) & mask) == '0;
      filled = (fill >= (len_r - 1'b1));
      // rst gating forces z low during reset, since the history is being cleared.
      z      = rst & in_valid & ~cfg_load & ~cfg_err & filled & pat_eq;
   end

   // Active configuration and bit history; a load or non-overlap match restarts the search.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_r <= DEF_PAT;
         len_r <= LEN_W'(DEF_LEN);
         ovl_r <= DEF_OVL;
         hist  <= '0;
         fill  <= '0;
      end else if (cfg_load) begin
         pat_r <= pattern;
         len_r <= pat_len;
         ovl_r <= overlap;
         hist  <= '0;
         fill  <= '0;
      end else if (in_valid) begin
         if (z && !ovl_r) begin
            hist <= '0;
            fill <= '0;
         end else begin
            hist <= window[N-2:0];
            fill <= fill_inc(fill);
         end
      end
   end

   // Registered match flag and saturating match counter; clear wins over increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         z_q       <= 1'b0;
         match_cnt <= '0;
      end else begin
         z_q <= z;
         if (clr_cnt) begin
            match_cnt <= '0;
         end else if (z) begin
            match_cnt <= cnt_inc(match_cnt);
         end
      end
   end

endmodule

// File: tb/tb_seq_det_param.sv
// Directed, table-driven bench for seq_det_param, with a second instance
// (CNT_W=2) sharing all inputs to exercise counter saturation.
`timescale 1ns/1ps
module tb_seq_det_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       x;
   logic       in_valid;
   logic       cfg_load;
   logic [7:0] pattern;
   logic [3:0] pat_len;
   logic       overlap;
   logic       clr_cnt;

   logic       z, z_q, cfg_err;
   logic [7:0] match_cnt;
   logic       z2, z_q2, cfg_err2;
   logic [1:0] match_cnt2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_det_param dut (
      .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
      .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .clr_cnt(clr_cnt),
      .z(z), .z_q(z_q), .match_cnt(match_cnt), .cfg_err(cfg_err)
   );

   seq_det_param #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
      .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .clr_cnt(clr_cnt),
      .z(z2), .z_q(z_q2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
   );

   typedef struct {
      bit         rl;    // hold reset low for this cycle
      bit         ld;
      logic [7:0] p;
      logic [3:0] l;
      bit         o;
      bit         v;
      bit         x;
      bit         c;
      bit         ez;    // z expected before the edge, z_q expected after it
      int         ecnt;  // match_cnt expected after the edge
      bit         eerr;  // cfg_err expected after the edge
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rl, bit ld, logic [7:0] p, logic [3:0] l, bit o,
                               bit v, bit xb, bit c, bit ez, int ecnt, bit eerr);
      vec_t t;
      t.rl = rl; t.ld = ld; t.p = p; t.l = l; t.o = o;
      t.v = v; t.x = xb; t.c = c; t.ez = ez; t.ecnt = ecnt; t.eerr = eerr;
      return t;
   endfunction

   function automatic vec_t vb(bit xb, bit ez, int ecnt, bit eerr);
      return mk(0, 0, 8'h00, 4'd0, 0, 1, xb, 0, ez, ecnt, eerr);
   endfunction

   function automatic vec_t idle(bit xb, int ecnt, bit eerr);
      return mk(0, 0, 8'h00, 4'd0, 0, 0, xb, 0, 0, ecnt, eerr);
   endfunction

   function automatic vec_t clr(bit eerr);
      return mk(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 0, eerr);
   endfunction

   function automatic vec_t lda(logic [7:0] p, logic [3:0] l, bit o, int ecnt, bit eerr);
      return mk(0, 1, p, l, o, 0, 0, 0, 0, ecnt, eerr);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Drive one row just after a falling edge, check z, then check registered state.
   task automatic step(input vec_t t, input int idx);
      rst      = ~t.rl;
      cfg_load = t.ld;
      pattern  = t.p;
      pat_len  = t.l;
      overlap  = t.o;
      in_valid = t.v;
      x        = t.x;
      clr_cnt  = t.c;
      #1;
      chk($sformatf("z[%0d]", idx), 32'(z), 32'(t.ez));
      @(posedge clk);
      #1;
      chk($sformatf("match_cnt[%0d]", idx), 32'(match_cnt), 32'(t.ecnt));
      chk($sformatf("z_q[%0d]", idx), 32'(z_q), 32'(t.ez));
      chk($sformatf("cfg_err[%0d]", idx), 32'(cfg_err), 32'(t.eerr));
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; x = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
      pattern = 8'h00; pat_len = 4'd0; overlap = 1'b0; clr_cnt = 1'b0;

      // Defaults 1010, non-overlap: match only on bit 4
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(vb(0, 0, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(vb(0, 1, 1, 0));
      tbl.push_back(vb(1, 0, 1, 0));
      tbl.push_back(vb(0, 0, 1, 0));
      tbl.push_back(clr(0));
      // Overlap mode: matches on bits 4 and 6
      tbl.push_back(lda(8'h0A, 4'd4, 1, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(vb(0, 0, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(vb(0, 1, 1, 0));
      tbl.push_back(vb(1, 0, 1, 0));
      tbl.push_back(vb(0, 1, 2, 0));
      tbl.push_back(clr(0));
      // 8-bit pattern 1101_0011 with an in_valid gap after bit 5
      tbl.push_back(lda(8'hD3, 4'd8, 0, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(vb(0, 0, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(vb(0, 0, 0, 0));
      tbl.push_back(idle(1, 0, 0));
      tbl.push_back(idle(0, 0, 0));
      tbl.push_back(idle(1, 0, 0));
      tbl.push_back(vb(0, 0, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(vb(1, 1, 1, 0));
      tbl.push_back(clr(0));
      // Illegal lengths 0 and 9: cfg_err, never z
      tbl.push_back(lda(8'h0A, 4'd0, 0, 0, 1));
      tbl.push_back(vb(1, 0, 0, 1));
      tbl.push_back(vb(0, 0, 0, 1));
      tbl.push_back(vb(1, 0, 0, 1));
      tbl.push_back(vb(0, 0, 0, 1));
      tbl.push_back(lda(8'h0A, 4'd9, 0, 0, 1));
      tbl.push_back(vb(1, 0, 0, 1));
      tbl.push_back(vb(0, 0, 0, 1));
      // Load during partial 101 discards the bit and the history
      tbl.push_back(lda(8'h0A, 4'd4, 0, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(vb(0, 0, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 8'h0A, 4'd4, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(vb(0, 0, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(vb(0, 0, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(vb(0, 1, 1, 0));
      tbl.push_back(clr(0));
      // Reset mid-sequence with pattern 0101 loaded: defaults and empty history return
      tbl.push_back(lda(8'h05, 4'd4, 1, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(vb(0, 0, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(vb(0, 0, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(vb(0, 0, 0, 0));
      tbl.push_back(vb(1, 0, 0, 0));
      tbl.push_back(vb(0, 1, 1, 0));

      // Reset state while rst is held low
      repeat (2) @(negedge clk);
      in_valid = 1'b1; x = 1'b1;
      #1;
      chk("reset_z", 32'(z), 32'd0);
      chk("reset_z_q", 32'(z_q), 32'd0);
      chk("reset_match_cnt", 32'(match_cnt), 32'd0);
      chk("reset_cfg_err", 32'(cfg_err), 32'd0);
      in_valid = 1'b0; x = 1'b0;
      @(negedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i], i);
      end

      // Single-bit pattern with a 2-bit counter: saturation at 3, then clear beats a match
      step(mk(0, 1, 8'h01, 4'd1, 1, 0, 0, 1, 0, 0, 0), 1000);
      chk("sat_cnt2_clr", 32'(match_cnt2), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         step(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 0, 1, k, 0), 1000 + k);
         chk($sformatf("sat_cnt2[%0d]", k), 32'(match_cnt2), 32'((k > 3) ? 3 : k));
         chk($sformatf("sat_z2[%0d]", k), 32'({z_q2, cfg_err2}), 32'd2);
      end
      step(mk(0, 0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 0, 0), 1010);
      chk("sat_cnt2_clr_match", 32'(match_cnt2), 32'd0);
      in_valid = 1'b0;
      #1;
      chk("sat_z2_idle", 32'(z2), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
